// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan reader: digit count,
// segment bit positions, the hex glyph table and anode classification helpers.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  typedef logic [7:0] seg_t;
  typedef seg_t [NUM_DIGITS-1:0] seg_frame_t;

  typedef enum logic [1:0] {
    AN_BLANK,
    AN_ONEHOT,
    AN_MULTI
  } an_class_e;

  // Active-high a..g patterns for hex values 0..F (index = value).
  localparam logic [0:15][6:0] GLYPHS = {
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic an_class_e an_classify(input logic [NUM_DIGITS-1:0] an);
    if (an == '0) return AN_BLANK;
    if ((an & (an - 1'b1)) == '0) return AN_ONEHOT;
    return AN_MULTI;
  endfunction

  function automatic logic [2:0] an_index(input logic [NUM_DIGITS-1:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational glyph matcher: maps a segment pattern (dp ignored) to its hex
// value; unmatched or all-off patterns report known_o=0 and hex_o=0.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  seg_t       seg_i,
  output logic [3:0] hex_o,
  output logic       known_o
);

  seg_t seg_nodp;

  always_comb begin
    seg_nodp = seg_i & 8'hFE;
    hex_o    = 4'd0;
    known_o  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (seg_nodp == {GLYPHS[k], 1'b0}) begin
        hex_o   = 4'(k);
        known_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Loopback reader for the multiplexed 7-segment bus: qualifies stable digits,
// assembles frames and publishes snapshots. Define SEG7_HEX_DECODE_EN for hex readback.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic [7:0]  DIGIT_MASK    = 8'hFF
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       CA,
  input  logic       CB,
  input  logic       CC,
  input  logic       CD,
  input  logic       CE,
  input  logic       CF,
  input  logic       CG,
  input  logic       DP,
  input  logic [7:0] AN,
  output logic       frame_valid,
  input  logic       frame_ack,
  output logic       err_multi,
  output logic       overrun,
  input  logic [2:0] rd_idx,
  output logic [7:0] rd_seg,
  output logic [3:0] rd_hex,
  output logic       rd_known
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

  logic [15:0] sync1_q, sync2_q;
  logic [15:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  seg_frame_t  work_q, work_d;
  seg_frame_t  snap_q, snap_d;
  logic [7:0]  seen_q, seen_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        ovr_q, ovr_d;

  seg_t        seg_s;
  logic [7:0]  an_s;
  logic [15:0] sample;
  logic        same, hit, complete, ack_eff, load;
  logic [2:0]  hit_idx;

  // Synchronizers idle high so the reset state reads as "nothing lit".
  always_comb begin
    an_s          = ~sync2_q[15:8];
    seg_s         = '0;
    seg_s[SEG_A]  = ~sync2_q[7];
    seg_s[SEG_B]  = ~sync2_q[6];
    seg_s[SEG_C]  = ~sync2_q[5];
    seg_s[SEG_D]  = ~sync2_q[4];
    seg_s[SEG_E]  = ~sync2_q[3];
    seg_s[SEG_F]  = ~sync2_q[2];
    seg_s[SEG_G]  = ~sync2_q[1];
    seg_s[SEG_DP] = ~sync2_q[0];
    sample        = {an_s, seg_s};
  end

  always_comb begin
    same     = (sample == prev_q);
    cnt_d    = same ? ((cnt_q == STABLE_C) ? cnt_q : cnt_q + 8'd1) : 8'd0;
    hit      = same && (cnt_q == STABLE_C - 8'd1);
    hit_idx  = an_index(an_s);
    complete = ((seen_q & DIGIT_MASK) == DIGIT_MASK);
    ack_eff  = frame_ack && valid_q;
    load     = complete && (!valid_q || frame_ack);

    work_d  = work_q;
    seen_d  = seen_q;
    snap_d  = snap_q;
    valid_d = valid_q;
    err_d   = err_q;
    ovr_d   = ovr_q;

    if (ack_eff) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      ovr_d   = 1'b0;
    end

    if (complete) begin
      seen_d = '0;
      if (load) begin
        snap_d  = work_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    // A fresh error event wins over an ack in the same cycle so it is not lost.
    if (hit) begin
      unique case (an_classify(an_s))
        AN_ONEHOT: begin
          work_d[hit_idx] = seg_s;
          seen_d[hit_idx] = 1'b1;
        end
        AN_MULTI: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      snap_q  <= '0;
      seen_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= {AN, CA, CB, CC, CD, CE, CF, CG, DP};
      sync2_q <= sync1_q;
      prev_q  <= sample;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      snap_q  <= snap_d;
      seen_q  <= seen_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign frame_valid = valid_q;
  assign err_multi   = err_q;
  assign overrun     = ovr_q;
  assign rd_seg      = snap_q[rd_idx];

`ifdef SEG7_HEX_DECODE_EN
  seg7_hex_decode u_hex_decode (
    .seg_i   (rd_seg),
    .hex_o   (rd_hex),
    .known_o (rd_known)
  );
`else
  assign rd_hex   = 4'd0;
  assign rd_known = 1'b0;
`endif

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Loopback reader for the multiplexed 7-segment display bus. It samples the active-low segment lines (CA..CG, DP) and anode lines (AN) driven by any display block on the board, and qualifies each lit digit over a stability window. Qualified segment patterns are stored per digit position, and a completed frame is published as a snapshot with a valid/ack handshake. Snapshot digits can be read back as raw segments and as decoded hex, so display logic can be self-checked on hardware and in simulation.

## Interface
Parameters:
- STABLE_CYCLES, 16: consecutive identical samples required to commit a digit; legal range 2..255.
- DIGIT_MASK, 8'hFF: digit positions that must be committed to complete a frame.

Ports:
- CLK100MHZ  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- CA, CB, CC, CD, CE, CF, CG, DP  in  1 each  active-low segment lines a..g and decimal point.
- AN  in  8  active-low anode lines; bit i selects digit i.
- frame_valid  out  1  snapshot holds a complete frame.
- frame_ack  in  1  consumer releases the snapshot.
- err_multi  out  1  sticky; more than one anode was seen active.
- overrun  out  1  sticky; a frame completed while frame_valid=1 and no ack was given.
- rd_idx  in  3  snapshot digit select.
- rd_seg  out  8  snapshot segments {a,b,c,d,e,f,g,dp}, active-high.
- rd_hex  out  4  decoded value of segments a..g.
- rd_known  out  1  a..g matches a hex glyph.

## Operation
- Input stage: 2-flop synchronizer on all 16 lines. The flops reset to 1, which is the idle level. After synchronization the lines are inverted internally: seg[7:0]={a..g,dp}, an=~AN.
- Stability counter:
  - Compares {an,seg} with the previous sample.
  - Equal: the counter increments, saturating at STABLE_CYCLES.
  - Different: the counter clears to 0.
- Commit happens on the cycle the counter first reaches STABLE_CYCLES. At most one commit per stable run.
  - an one-hot: work[i]<=seg; seen[i]<=1.
  - an==0: blank. No commit, no error.
  - an has more than one bit set: no commit; err_multi<=1.
- Frame completion: when (seen & DIGIT_MASK)==DIGIT_MASK, seen clears to 0.
  - If frame_valid=0, or frame_ack=1 in the same cycle: snapshot<=work and frame_valid<=1.
  - Otherwise the new frame is discarded and overrun<=1; the old snapshot is kept.
- Handshake:
  - frame_ack while frame_valid=1 clears frame_valid, err_multi and overrun on the next edge, unless a new frame loads in the same cycle. In that case frame_valid stays 1 and the errors still clear.
  - frame_ack while frame_valid=0 is ignored.
- Readback: rd_seg, rd_hex and rd_known are combinational from snapshot[rd_idx].
- Decoding:
  - Standard glyphs 0-9 and A,b,C,d,E,F; dp is ignored.
  - Any other pattern gives rd_hex=0 and rd_known=0.
  - An all-off pattern gives rd_known=0.

## Timing
- Reset: frame_valid, err_multi, overrun=0; snapshot, work, seen and the counter are 0. Hence rd_seg=0, rd_hex=0, rd_known=0.
- Latency:
  - An input change captured at edge k reaches the comparator at edge k+2.
  - A digit stable from then on commits at edge k+2+STABLE_CYCLES.
  - frame_valid rises one edge after the final commit.
- Reset mid-frame discards partial work. The first frame after release requires every masked digit again.
- A glitch of shorter than STABLE_CYCLES restarts the run and does not commit.
- Re-commit of an already-seen digit within a frame overwrites work[i].

## Configuration
- SEG7_HEX_DECODE_EN defined: the hex decoder is instantiated and rd_hex/rd_known behave as described.
- Undefined: rd_hex=0 and rd_known=0 constantly, no decode logic is built, and the ports remain.

## Structure
- Package seg7_pkg holds:
  - NUM_DIGITS=8 and segment bit-index constants (SEG_A=7 .. SEG_DP=0).
  - typedef seg_t (logic [7:0]) and seg_frame_t (seg_t [NUM_DIGITS-1:0]).
  - The 16-entry glyph table.
- Sub-module seg7_hex_decode: combinational seg_t to {hex, known}. It is instantiated once on the readback path, only under SEG7_HEX_DECODE_EN.

## Test plan
- Scan digits 0..7 with patterns for "01234567", each held 40 cycles, STABLE_CYCLES=16 → frame_valid=1; rd_idx=3 gives rd_seg=8'hF2, rd_hex=3, rd_known=1.
- Hold one digit for 10 cycles, then change it (STABLE_CYCLES=16) → no commit; seen unchanged; frame_valid stays 0.
- AN=8'b11111100 held 40 cycles → err_multi=1 and no commit; frame_ack → err_multi=0 next edge.
- Complete two frames without ack → overrun=1 and the snapshot still equals frame 1. Ack asserted on the cycle frame 3 completes → frame 3 loaded, frame_valid stays 1.
- Display pattern 8'b11000110 on digit 0 → rd_seg=8'hC6, rd_known=0, rd_hex=0; macro undefined → rd_hex=0 and rd_known=0 for all digits.
- Assert rst asynchronously mid-scan with 5 digits seen → all outputs 0 immediately; 8 fresh digit commits are needed before frame_valid rises.
